turf_bus_timeout_arb: RTL and testbench

Round-robin arbiter sharing the single TURF register bus (en/wr/adr/dat/ack) between NMASTER requesters (UDP control path, PCIe request/response bridge, future event controller). It adds a bus watchdog: a transaction that receives no slave ack within TIMEOUT cycles is terminated with an error response, so a missing or hung register slave cannot lock out the other masters. It sits between the requesters and turf_register_core in the ifclk domain.

---
 rtl/turf_bus_pkg.sv | 20 ++
 rtl/turf_bus_timeout_arb_if.sv | 36 +++
 rtl/turf_rr_select.sv | 33 +++
 rtl/turf_bus_timeout_arb.sv | 143 ++++++++++++++
 tb/tb_turf_bus_timeout_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/turf_bus_pkg.sv
// rtl/turf_bus_pkg.sv - shared defaults and FSM encoding for the TURF bus arbiter
package turf_bus_pkg;

  localparam int          DEF_ADDR_BITS = 28;
  localparam int          DEF_DATA_BITS = 32;
  localparam logic [31:0] DEF_ERR_DATA  = 32'hBADACCE5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_COOL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    RESP = ST_RESP,
    COOL = ST_COOL
  } state_e;

endpackage

// File: rtl/turf_bus_timeout_arb_if.sv
// rtl/turf_bus_timeout_arb_if.sv - requester and shared register bus signal bundle
interface turf_bus_timeout_arb_if
  import turf_bus_pkg::*;
#(
  parameter int NMASTER   = 2,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
);

  logic [NMASTER-1:0]           s_en_i;
  logic [NMASTER-1:0]           s_wr_i;
  logic [NMASTER*ADDR_BITS-1:0] s_adr_i;
  logic [NMASTER*DATA_BITS-1:0] s_dat_i;
  logic [NMASTER*DATA_BITS-1:0] s_dat_o;
  logic [NMASTER-1:0]           s_ack_o;
  logic [NMASTER-1:0]           s_err_o;
  logic                         m_en_o;
  logic                         m_wr_o;
  logic [ADDR_BITS-1:0]         m_adr_o;
  logic [DATA_BITS-1:0]         m_dat_o;
  logic [DATA_BITS-1:0]         m_dat_i;
  logic                         m_ack_i;

  // Arbiter side: sees requesters and the register slave
  modport slave (
    input  s_en_i, s_wr_i, s_adr_i, s_dat_i, m_dat_i, m_ack_i,
    output s_dat_o, s_ack_o, s_err_o, m_en_o, m_wr_o, m_adr_o, m_dat_o
  );

  // Environment side: requesters plus the register slave
  modport master (
    output s_en_i, s_wr_i, s_adr_i, s_dat_i, m_dat_i, m_ack_i,
    input  s_dat_o, s_ack_o, s_err_o, m_en_o, m_wr_o, m_adr_o, m_dat_o
  );

endinterface

// File: rtl/turf_rr_select.sv
// rtl/turf_rr_select.sv - round-robin pick of the first eligible requester at or after a pointer
module turf_rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0] elig;
  int           j;

  assign elig = req_i & ~mask_i;

  // Scan from ptr upward with wrap; the first eligible hit wins
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!valid_o && elig[j[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/turf_bus_timeout_arb.sv
// rtl/turf_bus_timeout_arb.sv - round-robin TURF register bus arbiter with ack watchdog
module turf_bus_timeout_arb
  import turf_bus_pkg::*;
#(
  parameter int                   NMASTER   = 2,
  parameter int                   ADDR_BITS = DEF_ADDR_BITS,
  parameter int                   DATA_BITS = DEF_DATA_BITS,
  parameter int                   TIMEOUT   = 255,
  parameter logic [DATA_BITS-1:0] ERR_DATA  = DEF_ERR_DATA
) (
  input  logic                   clk,
  input  logic                   rst,
  turf_bus_timeout_arb_if.slave  bus,
  output logic [15:0]            timeout_count_o
);

  localparam int          IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_e                       state_q, state_d;
  logic [IW-1:0]                g_q, g_d;
  logic [IW-1:0]                ptr_q, ptr_d;
  logic                         wr_q, wr_d;
  logic [ADDR_BITS-1:0]         adr_q, adr_d;
  logic [DATA_BITS-1:0]         dat_q, dat_d;
  logic                         en_q, en_d;
  logic [15:0]                  wd_q, wd_d;
  logic [15:0]                  tcnt_q, tcnt_d;
  logic [NMASTER*DATA_BITS-1:0] sdat_q, sdat_d;
  logic [NMASTER-1:0]           ack_q, ack_d;
  logic [NMASTER-1:0]           err_q, err_d;

  logic [NMASTER-1:0]           mask;
  logic [IW-1:0]                sel_idx;
  logic                         sel_valid;

  // The requester just served is held off for the cooldown cycle
  assign mask = (state_q == COOL) ? (NMASTER'(1) << g_q) : '0;

  turf_rr_select #(.N(NMASTER), .IW(IW)) u_sel (
    .req_i   (bus.s_en_i),
    .mask_i  (mask),
    .ptr_i   (ptr_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    en_d    = en_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    sdat_d  = sdat_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          g_d     = sel_idx;
          wr_d    = bus.s_wr_i[sel_idx];
          adr_d   = bus.s_adr_i[sel_idx*ADDR_BITS +: ADDR_BITS];
          dat_d   = bus.s_dat_i[sel_idx*DATA_BITS +: DATA_BITS];
          en_d    = 1'b1;
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // An ack on the final watchdog cycle still counts as success
        if (bus.m_ack_i) begin
          sdat_d[g_q*DATA_BITS +: DATA_BITS] = bus.m_dat_i;
          ack_d[g_q] = 1'b1;
          en_d       = 1'b0;
          state_d    = RESP;
        end else if (wd_q == TO) begin
          sdat_d[g_q*DATA_BITS +: DATA_BITS] = ERR_DATA;
          ack_d[g_q] = 1'b1;
          err_d[g_q] = 1'b1;
          en_d       = 1'b0;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          state_d    = RESP;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      RESP: begin
        ptr_d   = (int'(g_q) == NMASTER - 1) ? '0 : g_q + IW'(1);
        state_d = COOL;
      end
      COOL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any bus cycle in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      en_q    <= 1'b0;
      wd_q    <= '0;
      tcnt_q  <= '0;
      sdat_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
      sdat_q  <= sdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_en_o      = en_q;
  assign bus.m_wr_o      = wr_q;
  assign bus.m_adr_o     = adr_q;
  assign bus.m_dat_o     = dat_q;
  assign bus.s_dat_o     = sdat_q;
  assign bus.s_ack_o     = ack_q;
  assign bus.s_err_o     = err_q;
  assign timeout_count_o = tcnt_q;

endmodule

// File: tb/tb_turf_bus_timeout_arb.sv
// tb/tb_turf_bus_timeout_arb.sv - scoreboard bench for the TURF bus timeout arbiter
module tb_turf_bus_timeout_arb;
  import turf_bus_pkg::*;

  localparam int NM = 2;
  localparam int AB = 28;
  localparam int DB = 32;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hBADACCE5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tcnt;

  turf_bus_timeout_arb_if #(.NMASTER(NM), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  turf_bus_timeout_arb #(
    .NMASTER(NM), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .timeout_count_o (tcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_at = 0;
  logic [31:0] slave_data = 32'h0;
  logic        late_ack = 1'b0;
  int          en_len = 0;
  int          last_en_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int m, input logic wr, input logic [27:0] adr, input logic [31:0] dat);
    bus.s_wr_i[m]            = wr;
    bus.s_adr_i[m*AB +: AB]  = adr;
    bus.s_dat_i[m*DB +: DB]  = dat;
    bus.s_en_i[m]            = 1'b1;
  endtask

  task automatic push_exp(input int m, input logic [31:0] d, input logic e);
    exp_t x;
    x.idx = m;
    x.dat = d;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_acks(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.s_ack_o != '0) got++;
    end
    check("ack_wait", 64'(got), 64'(n));
  endtask

  // Register slave model: acks on the ack_at-th cycle of m_en_o (0 = never)
  initial begin
    bus.m_ack_i = 1'b0;
    bus.m_dat_i = '0;
    forever begin
      @(negedge clk);
      if (bus.m_en_o) en_len++;
      else begin
        if (en_len != 0) last_en_len = en_len;
        en_len = 0;
      end
      bus.m_ack_i = late_ack || (bus.m_en_o && ack_at != 0 && en_len == ack_at);
      bus.m_dat_i = slave_data;
    end
  end

  // Response monitor: pops the scoreboard on every s_ack_o pulse
  initial begin
    forever begin
      exp_t        e;
      logic [NM-1:0] ev;
      @(negedge clk);
      if (bus.s_ack_o != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 64'(bus.s_ack_o), 64'(0));
        end else begin
          e  = sb.pop_front();
          ev = '0;
          ev[e.idx] = 1'b1;
          check("ack_grant", 64'(bus.s_ack_o), 64'(ev));
          check("resp_data", 64'(bus.s_dat_o[e.idx*DB +: DB]), 64'(e.dat));
          check("resp_err", 64'(bus.s_err_o), e.err ? 64'(ev) : 64'(0));
        end
      end else if (bus.s_err_o != '0) begin
        check("err_without_ack", 64'(bus.s_err_o), 64'(0));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_cnt;
    bus.s_en_i  = '0;
    bus.s_wr_i  = '0;
    bus.s_adr_i = '0;
    bus.s_dat_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_en", 64'(bus.m_en_o), 64'(0));
    check("rst_ack", 64'(bus.s_ack_o), 64'(0));
    check("rst_dat", 64'(bus.s_dat_o), 64'(0));
    check("rst_tcnt", 64'(tcnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single read from master 0, ack in third bus cycle
    ack_at = 3;
    slave_data = 32'h12345678;
    set_req(0, 1'b0, 28'h0000004, 32'h0);
    push_exp(0, 32'h12345678, 1'b0);
    @(negedge clk);
    check("read_m_en", 64'(bus.m_en_o), 64'(1));
    check("read_adr", 64'(bus.m_adr_o), 64'h4);
    check("read_wr", 64'(bus.m_wr_o), 64'(0));
    wait_acks(1);
    bus.s_en_i[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Write from master 1, immediate ack; lane 0 must hold
    ack_at = 1;
    slave_data = 32'h00000001;
    set_req(1, 1'b1, 28'h0000123, 32'hCAFEF00D);
    push_exp(1, 32'h00000001, 1'b0);
    @(negedge clk);
    check("write_wr", 64'(bus.m_wr_o), 64'(1));
    check("write_adr", 64'(bus.m_adr_o), 64'h123);
    check("write_dat", 64'(bus.m_dat_o), 64'hCAFEF00D);
    wait_acks(1);
    check("lane0_hold", 64'(bus.s_dat_o[0 +: DB]), 64'h12345678);
    bus.s_en_i[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: grants must alternate 0,1,0,1
    ack_at = 1;
    slave_data = 32'h55AA0000;
    set_req(0, 1'b0, 28'h10, 32'h0);
    set_req(1, 1'b0, 28'h20, 32'h0);
    for (int k = 0; k < 4; k++) push_exp(k % 2, 32'h55AA0000, 1'b0);
    wait_acks(4);
    bus.s_en_i = '0;
    repeat (2) @(negedge clk);

    // Timeout: slave never acks, then a late ack must be ignored
    ack_at = 0;
    set_req(0, 1'b0, 28'hBEEF, 32'h0);
    push_exp(0, ERRD, 1'b1);
    wait_acks(1);
    bus.s_en_i[0] = 1'b0;
    check("timeout_count_1", 64'(tcnt), 64'(1));
    @(negedge clk);
    check("timeout_en_len", 64'(last_en_len), 64'(TO + 1));
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("late_ack_count", 64'(tcnt), 64'(1));
    check("late_ack_sb", 64'(sb.size()), 64'(0));

    // Ack exactly on the final watchdog cycle counts as success
    ack_at = TO + 1;
    slave_data = 32'h0BADF00D;
    set_req(1, 1'b1, 28'h77, 32'h1);
    push_exp(1, 32'h0BADF00D, 1'b0);
    wait_acks(1);
    bus.s_en_i[1] = 1'b0;
    @(negedge clk);
    check("edge_en_len", 64'(last_en_len), 64'(TO + 1));
    check("edge_count", 64'(tcnt), 64'(1));
    @(negedge clk);

    // Serve master 0 so the pointer moves to 1, then reset mid-BUSY
    ack_at = 1;
    slave_data = 32'h11112222;
    set_req(0, 1'b0, 28'h8, 32'h0);
    push_exp(0, 32'h11112222, 1'b0);
    wait_acks(1);
    bus.s_en_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    ack_at = 0;
    set_req(0, 1'b0, 28'h9, 32'h0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(bus.m_en_o), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_m_en", 64'(bus.m_en_o), 64'(0));
    check("rst_busy_adr", 64'(bus.m_adr_o), 64'(0));
    check("rst_busy_ack", 64'(bus.s_ack_o), 64'(0));
    check("rst_busy_err", 64'(bus.s_err_o), 64'(0));
    check("rst_busy_dat", 64'(bus.s_dat_o), 64'(0));
    check("rst_busy_tcnt", 64'(tcnt), 64'(0));
    ack_at = 1;
    slave_data = 32'h33334444;
    set_req(1, 1'b0, 28'hA, 32'h0);
    push_exp(0, 32'h33334444, 1'b0);
    push_exp(1, 32'h33334444, 1'b0);
    rst = 1'b0;
    wait_acks(2);
    bus.s_en_i = '0;
    repeat (2) @(negedge clk);

    // Saturation: preload the counter near its ceiling, then time out three times
    force dut.tcnt_q = 16'hFFFD;
    @(negedge clk);
    release dut.tcnt_q;
    @(negedge clk);
    check("sat_preload", 64'(tcnt), 64'hFFFD);
    exp_cnt = 16'hFFFD;
    ack_at = 0;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b0, 28'h100, 32'h0);
      push_exp(0, ERRD, 1'b1);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      wait_acks(1);
      bus.s_en_i[0] = 1'b0;
      check("sat_count", 64'(tcnt), 64'(exp_cnt));
      repeat (2) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
